// File: rtl/input_reader_if.sv
// rtl/input_reader_if.sv - captured-word handshake between input_reader and its consumer
interface input_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/input_reader.sv
// rtl/input_reader.sv - debounced pushbutton that captures the slide-switch word per press
module input_reader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_n,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  overrun_clr,
  output logic                  overrun,
  output logic                  key_level,
  input_reader_if.master        bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic                  r_key_meta;
  logic                  r_key_sync;
  logic [DATA_WIDTH-1:0] r_sw_meta;
  logic [DATA_WIDTH-1:0] r_sw_sync;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_key_level;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overrun;

  logic                  w_press;
  logic                  w_xfer;

  // Key idles released (high) so reset never fabricates a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= key_n;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RELEASED;
      r_cnt       <= '0;
      r_key_level <= 1'b0;
    end else begin
      case (r_state)
        RELEASED: begin
          r_cnt <= '0;
          if (!r_key_sync) r_state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (r_key_sync) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= PRESSED;
            r_cnt       <= '0;
            r_key_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PRESSED: begin
          r_cnt <= '0;
          if (r_key_sync) r_state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (!r_key_sync) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= RELEASED;
            r_cnt       <= '0;
            r_key_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign w_press = (r_state == PRESS_WAIT) && !r_key_sync && (r_cnt == CNT_LAST);
  assign w_xfer  = r_data_valid && bus.data_ready;

  // A press coinciding with a transfer refills the slot instead of counting as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_press && (!r_data_valid || w_xfer)) begin
        r_data_out   <= r_sw_sync;
        r_data_valid <= 1'b1;
      end else if (w_xfer) begin
        r_data_valid <= 1'b0;
      end

      if (w_press && r_data_valid && !w_xfer) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign overrun        = r_overrun;
  assign key_level      = r_key_level;

endmodule

// File: doc/input_reader.md
INPUT_READER -- requirements
Module: input_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, consecutive cycles a key level must hold before it is accepted (legal range 2..2^20).
REQ-002 Parameter DATA_WIDTH, default 8, width of switch bus and captured word.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_n  input  1  raw pushbutton, asynchronous, bouncing, low = pressed.
REQ-006 sw  input  DATA_WIDTH  raw slide switches, asynchronous.
REQ-007 data_out  output  DATA_WIDTH  captured switch word.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 data_ready  input  1  consumer accepts data_out this cycle.
REQ-010 overrun  output  1  sticky; a press was dropped while a word was pending.
REQ-011 overrun_clr  input  1  synchronous clear of overrun.
REQ-012 key_level  output  1  debounced key state, 1 = pressed.

Function
REQ-013 key_n and every sw bit SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Debouncer SHALL be a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 RELEASED -> PRESS_WAIT when synchronized key is low; PRESSED -> RELEASE_WAIT when synchronized key is high.
REQ-016 In PRESS_WAIT/RELEASE_WAIT a counter SHALL increment each cycle the synchronized key keeps the new level; any cycle with the old level SHALL zero the counter and return to RELEASED/PRESSED respectively.
REQ-017 PRESS_WAIT -> PRESSED when the counter reaches DEBOUNCE_CYCLES-1 with key still low; RELEASE_WAIT -> RELEASED likewise with key high; counter zeroed on every state change.
REQ-018 key_level SHALL be 1 exactly in PRESSED and RELEASE_WAIT.
REQ-019 A press event SHALL be generated only on the PRESS_WAIT -> PRESSED transition; release generates no event; one press = at most one event.
REQ-020 Latency: with clean input, counting the first edge sampling key_n low as edge 1, data_valid and key_level SHALL be high after edge DEBOUNCE_CYCLES+3.
REQ-021 On a press event with data_valid low, data_out SHALL load synchronized sw and data_valid SHALL set on that edge.
REQ-022 While data_valid is high, data_out SHALL not change except under REQ-024.
REQ-023 Transfer occurs on an edge where data_valid and data_ready are both high; data_valid SHALL clear on that edge unless REQ-024 applies.
REQ-024 Press event on the same edge as a transfer: data_out loads new sw, data_valid stays high, overrun unchanged.
REQ-025 Press event with data_valid high and no transfer: word dropped, data_out unchanged, overrun SHALL set.
REQ-026 overrun_clr clears overrun next edge; simultaneous set and clear: set wins.
REQ-027 data_ready with data_valid low SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force: FSM RELEASED, counter 0, key synchronizer flops 1, sw synchronizer flops 0, data_out 0, data_valid 0, overrun 0, key_level 0.
REQ-029 Reset mid-debounce or with a word pending SHALL discard all state; a key held through deassertion SHALL be detected as a new press after REQ-020 latency.

Verification (DEBOUNCE_CYCLES=4, DATA_WIDTH=8)
REQ-030 Clean press, sw=0xA5, data_ready=0 -> data_valid and key_level high after edge 7, data_out=0xA5, overrun=0.
REQ-031 key_n bounces low 2 cycles / high 1 cycle repeatedly, then stable low -> exactly one word captured, 7 edges after stable-low start.
REQ-032 Word pending (0x11), second press with sw=0x22, data_ready=0 -> data_out stays 0x11, overrun=1; overrun_clr pulse -> overrun=0.
REQ-033 data_ready held 1, press timed so event coincides with transfer of 0x33, sw=0x44 -> data_valid stays high, data_out=0x44, overrun=0.
REQ-034 rst_n pulsed low while in PRESS_WAIT with key held -> all outputs 0 immediately; after release of reset, data_valid high after edge 7.
REQ-035 Press held 100 cycles, released, re-pressed -> two words total; no event on release; key_level tracks debounced level.
